// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT control and a single
// output register toward decode with a valid/ready handshake.
module instr_fetch #(
  parameter int unsigned              IMEM_BITS = 22,
  parameter logic [IMEM_BITS-1:0]     RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [IMEM_BITS-1:0] redirect_pc,
  input  logic                 halt,
  output logic [IMEM_BITS-1:0] imem_addr,
  input  logic [31:0]          imem_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [IMEM_BITS-1:0] out_pc,
  output logic [31:0]          fetch_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [IMEM_BITS-1:0] PC_ONE = {{(IMEM_BITS-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [IMEM_BITS-1:0] r_pc;
  logic                 r_out_valid;
  logic [31:0]          r_out_instr;
  logic [IMEM_BITS-1:0] r_out_pc;
  logic [31:0]          r_fetch_count;

  logic                 w_fetch;
  logic                 w_handshake;
  logic [IMEM_BITS-1:0] w_pc_inc;

  // Fetch only in RUN with no redirect/halt and room in the output register;
  // the PC increment wraps naturally at the address width.
  always_comb begin
    w_fetch     = (r_state == RUN) && !redirect_valid && !halt &&
                  (!r_out_valid || out_ready);
    w_handshake = r_out_valid && out_ready;
    w_pc_inc    = r_pc + PC_ONE;
  end

  // Control FSM and PC; a redirect wins over everything and always lands in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else if (redirect_valid) begin
      r_state <= RUN;
      r_pc    <= redirect_pc;
    end else begin
      case (r_state)
        IDLE: r_state <= RUN;
        RUN: begin
          if (halt)         r_state <= HALT;
          else if (w_fetch) r_pc    <= w_pc_inc;
        end
        HALT:    r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output register: load on fetch, drop on redirect or on a bare handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
    end else if (redirect_valid) begin
      r_out_valid <= 1'b0;
    end else if (w_fetch) begin
      r_out_valid <= 1'b1;
      r_out_instr <= imem_data;
      r_out_pc    <= r_pc;
    end else if (w_handshake) begin
      r_out_valid <= 1'b0;
    end
  end

  // Count of instructions loaded into the output register; wraps at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_fetch_count <= '0;
    else if (w_fetch) r_fetch_count <= r_fetch_count + 32'd1;
  end

  assign imem_addr   = r_pc;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory word k holds k+100.
module tb_instr_fetch;

  localparam int AW = 22;

  logic          clk;
  logic          reset;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_pc;
  logic [31:0]   fetch_count;

  int checks   = 0;
  int failures = 0;

  instr_fetch #(.IMEM_BITS(AW), .RESET_PC('0)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fetch_count   (fetch_count)
  );

  assign imem_data = {10'd0, imem_addr} + 32'd100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rv;
    logic [AW-1:0] rpc;
    logic          h;
    logic          rdy;
    logic          ev;
    logic [AW-1:0] epc;
    logic [31:0]   einstr;
    logic [31:0]   ecnt;
    logic [AW-1:0] eaddr;
  } vec_t;

  function automatic vec_t mk(int rv, int rpc, int h, int rdy,
                              int ev, int epc, int ei, int ec, int ea);
    vec_t v;
    v.rv = rv[0]; v.rpc = rpc[AW-1:0]; v.h = h[0]; v.rdy = rdy[0];
    v.ev = ev[0]; v.epc = epc[AW-1:0]; v.einstr = ei; v.ecnt = ec;
    v.eaddr = ea[AW-1:0];
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=0x%0h exp=0x%0h", name, idx, got, exp);
    end
  endtask

  // Drive one vector, take one edge, compare just after it.
  task automatic apply(input vec_t v, input int idx);
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    halt           = v.h;
    out_ready      = v.rdy;
    @(posedge clk);
    #1;
    chk("out_valid", idx, {31'd0, out_valid}, {31'd0, v.ev});
    chk("imem_addr", idx, {10'd0, imem_addr}, {10'd0, v.eaddr});
    chk("fetch_count", idx, fetch_count, v.ecnt);
    if (v.ev) begin
      chk("out_pc", idx, {10'd0, out_pc}, {10'd0, v.epc});
      chk("out_instr", idx, out_instr, v.einstr);
    end
  endtask

  task automatic chk_zero(input int idx);
    chk("rst_valid", idx, {31'd0, out_valid}, 32'd0);
    chk("rst_pc", idx, {10'd0, out_pc}, 32'd0);
    chk("rst_instr", idx, out_instr, 32'd0);
    chk("rst_count", idx, fetch_count, 32'd0);
    chk("rst_addr", idx, {10'd0, imem_addr}, 32'd0);
  endtask

  vec_t tbl[24];

  initial begin
    //            rv rpc       h rdy ev epc       instr    cnt addr
    tbl[0]  = mk(0, 0,        0, 1,  0, 0,        0,       0,  0);
    tbl[1]  = mk(0, 0,        0, 1,  1, 0,        100,     1,  1);
    tbl[2]  = mk(0, 0,        0, 1,  1, 1,        101,     2,  2);
    tbl[3]  = mk(0, 0,        0, 1,  1, 2,        102,     3,  3);
    tbl[4]  = mk(0, 0,        0, 1,  1, 3,        103,     4,  4);
    tbl[5]  = mk(0, 0,        0, 1,  1, 4,        104,     5,  5);
    tbl[6]  = mk(0, 0,        0, 1,  1, 5,        105,     6,  6);
    tbl[7]  = mk(0, 0,        0, 0,  1, 5,        105,     6,  6);
    tbl[8]  = mk(0, 0,        0, 0,  1, 5,        105,     6,  6);
    tbl[9]  = mk(0, 0,        0, 0,  1, 5,        105,     6,  6);
    tbl[10] = mk(0, 0,        0, 1,  1, 6,        106,     7,  7);
    tbl[11] = mk(0, 0,        0, 0,  1, 6,        106,     7,  7);
    tbl[12] = mk(1, 'h40,     0, 0,  0, 0,        0,       7,  'h40);
    tbl[13] = mk(0, 0,        0, 0,  1, 'h40,     164,     8,  'h41);
    tbl[14] = mk(0, 0,        0, 1,  1, 'h41,     165,     9,  'h42);
    tbl[15] = mk(0, 0,        1, 0,  1, 'h41,     165,     9,  'h42);
    tbl[16] = mk(0, 0,        0, 0,  1, 'h41,     165,     9,  'h42);
    tbl[17] = mk(0, 0,        0, 1,  0, 0,        0,       9,  'h42);
    tbl[18] = mk(0, 0,        0, 1,  0, 0,        0,       9,  'h42);
    tbl[19] = mk(1, 'h10,     0, 1,  0, 0,        0,       9,  'h10);
    tbl[20] = mk(0, 0,        0, 1,  1, 'h10,     116,     10, 'h11);
    tbl[21] = mk(1, 'h3FFFFF, 0, 1,  0, 0,        0,       10, 'h3FFFFF);
    tbl[22] = mk(0, 0,        0, 1,  1, 'h3FFFFF, 4194403, 11, 0);
    tbl[23] = mk(0, 0,        0, 1,  1, 0,        100,     12, 1);

    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt = 1'b0; out_ready = 1'b0;

    // Held in reset across edges: everything zero.
    @(posedge clk); @(posedge clk); #1;
    chk_zero(-1);
    reset = 1'b1;

    for (int i = 0; i < 24; i++) apply(tbl[i], i);

    // Asynchronous reset between edges clears outputs at once.
    out_ready = 1'b1;
    #3 reset = 1'b0;
    #1 chk_zero(100);
    @(posedge clk); #1;
    reset = 1'b1;
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0), 101);
    apply(mk(0, 0, 0, 1, 1, 0, 100, 1, 1), 102);

    // Redirect during the IDLE cycle still enters RUN next edge.
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    apply(mk(1, 'h20, 0, 1, 0, 0, 0, 0, 'h20), 103);
    apply(mk(0, 0, 0, 1, 1, 'h20, 132, 1, 'h21), 104);

    // Redirect together with halt: redirect wins, no HALT entered.
    apply(mk(1, 'h30, 1, 1, 0, 0, 0, 1, 'h30), 105);
    apply(mk(0, 0, 0, 1, 1, 'h30, 148, 2, 'h31), 106);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter IMEM_BITS, default 22, meaning width of the word address driven to instruction memory.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning the word address fetched first after reset.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-low reset (0 = in reset).
REQ-005 SHALL have port redirect_valid, input, 1, meaning branch/jump redirect request this cycle.
REQ-006 SHALL have port redirect_pc, input, IMEM_BITS, meaning the new word address for a redirect.
REQ-007 SHALL have port halt, input, 1, meaning stop issuing new fetches.
REQ-008 SHALL have port imem_addr, output, IMEM_BITS, meaning the word address to instruction memory.
REQ-009 SHALL have port imem_data, input, 32, meaning the combinational read data for imem_addr in the same cycle.
REQ-010 SHALL have port out_valid, output, 1, meaning out_instr/out_pc hold a valid fetched instruction.
REQ-011 SHALL have port out_ready, input, 1, meaning the decode stage accepts the output this cycle.
REQ-012 SHALL have port out_instr, output, 32, meaning the registered fetched instruction.
REQ-013 SHALL have port out_pc, output, IMEM_BITS, meaning the word address of out_instr.
REQ-014 SHALL have port fetch_count, output, 32, meaning the number of instructions loaded into the output register since reset.

Function
REQ-015 SHALL implement states IDLE, RUN, HALT in a registered state machine.
REQ-016 SHALL drive imem_addr combinationally from the PC register at all times.
REQ-017 SHALL leave IDLE for RUN after exactly one clk edge following reset deassertion, with no fetch in the IDLE cycle, because memory is cleared during reset.
REQ-018 SHALL perform a fetch in RUN when redirect_valid=0, halt=0 and (out_valid=0 or out_ready=1): out_instr<=imem_data, out_pc<=PC, out_valid<=1, PC<=PC+1, fetch_count<=fetch_count+1.
REQ-019 SHALL clear out_valid on a handshake (out_valid=1, out_ready=1) with no fetch in the same cycle.
REQ-020 SHALL hold out_instr, out_pc and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL compute PC+1 modulo 2^IMEM_BITS, so the address after all-ones is 0 with no other effect.
REQ-022 SHALL give redirect_valid priority over halt, fetch and handshake: PC<=redirect_pc, out_valid<=0, no fetch that cycle, fetch_count unchanged; the first instruction from redirect_pc appears one cycle later.
REQ-023 SHALL, on a redirect in IDLE, load PC and still enter RUN on the next edge.
REQ-024 SHALL move RUN to HALT when halt=1 and redirect_valid=0, issuing no fetch that cycle.
REQ-025 SHALL, in HALT, issue no fetches, keep PC, and still allow a pending output to drain via handshake.
REQ-026 SHALL move HALT to RUN only on redirect_valid=1 (PC<=redirect_pc); deasserting halt alone does not leave HALT.
REQ-027 SHALL let fetch_count wrap from 2^32-1 to 0.

Reset
REQ-028 SHALL, while reset=0, asynchronously force state=IDLE, PC=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fetch_count=0.
REQ-029 SHALL abort any in-progress output or redirect on reset mid-operation; no state survives.

Verification
REQ-030 Reset release, out_ready=1, memory word k = k+100 -> out_valid first 1 two edges after release with out_pc=0, out_instr=100; then pc 1,2,3 on consecutive cycles.
REQ-031 out_ready=0 for 3 cycles at out_pc=5 -> out_instr/out_pc held at word 5, PC stays 6, fetch_count unchanged; resume gives pc 6 next.
REQ-032 redirect_valid=1, redirect_pc=0x40 while out_valid=1, out_ready=0 -> out_valid=0 next cycle, then out_pc=0x40.
REQ-033 halt=1 for one cycle, then deassert -> no further fetches; pending output drains; redirect to 0x10 -> RUN, out_pc=0x10.
REQ-034 redirect_pc=2^IMEM_BITS-1 -> out_pc=all-ones then 0.
REQ-035 reset=0 asserted mid-stream between edges -> outputs zero immediately; restart fetches RESET_PC, fetch_count restarts at 1.
